instr_fetch_unit: RTL and testbench

// - Upstream stage of the z8 control unit. Owns the PC register and fetches one 40-bit instruction per request.
// - Program memory is byte-wide, so each instruction takes 5 sequential byte reads.
// - Assembles the bytes and presents a stable instruction word plus PC to the control unit.
// - The control unit holds FETCH until instr_valid; the PC is reloaded from its next_pc at WRITEBACK.

---
 rtl/instr_fetch_unit_if.sv | 15 +
 rtl/instr_fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Program memory read bus between the fetch unit and byte-wide program memory.
//   rd_en    : read strobe, one byte per cycle
//   addr     : byte address (PMEM_AW bits)
//   rd_data  : read data, valid exactly one cycle after rd_en
// Modports: master = fetch unit, slave = program memory.
interface instr_fetch_unit_if #(
    parameter int PMEM_AW = 19
);
    logic               rd_en;
    logic [PMEM_AW-1:0] addr;
    logic [7:0]         rd_data;

    modport master (output rd_en, output addr, input rd_data);
    modport slave  (input rd_en, input addr, output rd_data);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for the z8 control unit. Owns the PC and assembles one
// 40-bit instruction from five sequential byte reads of program memory.
// Ports:
//   clk, reset     clock; synchronous active-high reset
//   fetch_req      pulse, start fetching the instruction at the (effective) pc
//   pc_load        strobe, pc <= next_pc on the next cycle
//   next_pc        PC value from the control unit
//   pc             current program counter
//   instruction    assembled word: [39:32] opcode, [31:16] dest, [15:0] src
//   instr_valid    instruction holds the fetch result for the current pc
//   busy           fetch in progress
//   pmem           program memory read bus (master side)
//   fetch_fault    pc out of range (only with IFU_BOUNDS_EN, else tied 0)
// Optional feature: define IFU_BOUNDS_EN to enable the program-bounds check.
//
// state  | meaning
// IDLE   | waiting for fetch_req
// ISSUE  | issuing the five byte reads (beat 0..4)
// DRAIN  | capturing the last byte and publishing the instruction word
module instr_fetch_unit #(
    parameter int         PROG_WORDS   = 4096,
    parameter int         BYTES_PER_IW = 5,
    parameter int         PMEM_AW      = 19,
    parameter logic [7:0] HALT_OPCODE  = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_req,
    input  logic                 pc_load,
    input  logic [15:0]          next_pc,
    output logic [15:0]          pc,
    output logic [39:0]          instruction,
    output logic                 instr_valid,
    output logic                 busy,
    instr_fetch_unit_if.master   pmem,
    output logic                 fetch_fault
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    localparam logic [2:0]  LAST_BEAT = 3'(BYTES_PER_IW - 1);
    localparam logic [39:0] HALT_WORD = {HALT_OPCODE, 32'h0};

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last_beat;
    logic [15:0]        eff_pc;
    logic [PMEM_AW-1:0] pc_ext;
    logic [PMEM_AW-1:0] base_calc;
    logic               bounds_hit;

    logic [2:0]         beat;
    logic               rd_en;
    logic [PMEM_AW-1:0] addr;
    logic               rd_q;
    logic [31:0]        asm_bytes;
    logic               stale;
    logic               halt_q;

    // A same-cycle pc_load steers the fetch to next_pc instead of the stale pc.
    assign eff_pc    = pc_load ? next_pc : pc;
    assign pc_ext    = PMEM_AW'(eff_pc);
    assign base_calc = (pc_ext << 2) + pc_ext;

`ifdef IFU_BOUNDS_EN
    assign bounds_hit = (32'(eff_pc) >= PROG_WORDS);
`else
    assign bounds_hit = 1'b0;
`endif

    assign pmem.rd_en = rd_en;
    assign pmem.addr  = addr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        last_beat  = 1'b0;
        case (state)
            S_IDLE: begin
                if (fetch_req) begin
                    accept     = 1'b1;
                    // An out-of-range fetch skips the reads and finishes next cycle.
                    state_next = bounds_hit ? S_DRAIN : S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (beat == LAST_BEAT) begin
                    last_beat  = 1'b1;
                    state_next = S_DRAIN;
                end
            end
            S_DRAIN: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= '0;
            instruction <= '0;
            instr_valid <= 1'b0;
            busy        <= 1'b0;
            rd_en       <= 1'b0;
            addr        <= '0;
            beat        <= '0;
            rd_q        <= 1'b0;
            asm_bytes   <= '0;
            stale       <= 1'b0;
            halt_q      <= 1'b0;
            fetch_fault <= 1'b0;
        end else begin
            if (pc_load) begin
                pc <= next_pc;
            end

            // rd_q marks the cycle in which read data is on the bus; it is
            // cleared by reset so data from an abandoned fetch is dropped.
            rd_q <= rd_en;
            if (rd_q) begin
                asm_bytes <= {asm_bytes[23:0], pmem.rd_data};
            end

            if (busy && pc_load) begin
                stale <= 1'b1;
            end

            if (accept) begin
                addr        <= base_calc;
                rd_en       <= ~bounds_hit;
                beat        <= '0;
                busy        <= 1'b1;
                instr_valid <= 1'b0;
                stale       <= 1'b0;
                halt_q      <= bounds_hit;
                fetch_fault <= 1'b0;
            end

            if (state == S_ISSUE) begin
                if (last_beat) begin
                    rd_en <= 1'b0;
                end else begin
                    beat <= beat + 3'd1;
                    addr <= addr + PMEM_AW'(1);
                end
            end

            if (state == S_DRAIN) begin
                busy        <= 1'b0;
                // The word no longer matches pc if it moved at any point in the fetch.
                instr_valid <= ~(stale | pc_load);
                instruction <= halt_q ? HALT_WORD : {asm_bytes, pmem.rd_data};
                fetch_fault <= halt_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    localparam int AW        = 19;
    localparam int MEM_BYTES = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic        pc_load;
    logic [15:0] next_pc;
    logic [15:0] pc;
    logic [39:0] instruction;
    logic        instr_valid;
    logic        busy;
    logic        fetch_fault;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [0:MEM_BYTES-1];
    int         rd_log [$];

    // reference state
    logic [15:0] m_pc;
    logic [39:0] m_instr;
    logic        m_valid;

    instr_fetch_unit_if #(.PMEM_AW(AW)) pmem_bus ();

    instr_fetch_unit dut (
        .clk         (clk),
        .reset       (reset),
        .fetch_req   (fetch_req),
        .pc_load     (pc_load),
        .next_pc     (next_pc),
        .pc          (pc),
        .instruction (instruction),
        .instr_valid (instr_valid),
        .busy        (busy),
        .pmem        (pmem_bus),
        .fetch_fault (fetch_fault)
    );

    always #5 clk = ~clk;

    // program memory: data one cycle after the strobe
    always @(posedge clk) begin
        if (pmem_bus.rd_en) pmem_bus.rd_data <= mem[pmem_bus.addr];
    end

    always @(negedge clk) begin
        if (pmem_bus.rd_en) rd_log.push_back(int'(pmem_bus.addr));
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model_word(input logic [15:0] p);
        logic [39:0] w;
        int          b;
        w = '0;
        b = int'(p) * 5;
        for (int k = 0; k < 5; k++) w = {w[31:0], mem[(b + k) % MEM_BYTES]};
        return w;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, "_pc"},    64'(pc),          64'(m_pc));
        check({tag, "_instr"}, 64'(instruction), 64'(m_instr));
        check({tag, "_valid"}, 64'(instr_valid), 64'(m_valid));
    endtask

    // called at a negedge with the bench idle
    task automatic load_pc(input logic [15:0] npc);
        pc_load = 1'b1;
        next_pc = npc;
        @(negedge clk);
        pc_load = 1'b0;
        m_pc    = npc;
        check("load_pc", 64'(pc), 64'(npc));
    endtask

    // mid_at: cycle T+mid_at (1..6) carries a pc_load, 0 = none
    task automatic fetch(input bit same_load, input logic [15:0] same_npc,
                         input int mid_at, input logic [15:0] mid_npc, input bit extra_req);
        logic [15:0] eff;
        bit          dirty;
        int          b;
        rd_log.delete();
        eff       = same_load ? same_npc : m_pc;
        fetch_req = 1'b1;
        pc_load   = same_load;
        next_pc   = same_npc;
        if (same_load) m_pc = same_npc;
        dirty = 1'b0;
        @(negedge clk);
        fetch_req = 1'b0;
        pc_load   = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            check("busy_in_fetch",  64'(busy),        64'd1);
            check("valid_in_fetch", 64'(instr_valid), 64'd0);
            check("instr_hidden",   64'(instruction), 64'(m_instr));
            if (c == mid_at) begin
                pc_load = 1'b1;
                next_pc = mid_npc;
                m_pc    = mid_npc;
                dirty   = 1'b1;
            end
            if (extra_req && c == 2) fetch_req = 1'b1;
            @(negedge clk);
            pc_load   = 1'b0;
            fetch_req = 1'b0;
        end
        m_instr = model_word(eff);
        m_valid = ~dirty;
        check_outputs("done");
        check("done_busy",  64'(busy),        64'd0);
        check("done_fault", 64'(fetch_fault), 64'd0);
        check("rd_count",   64'(rd_log.size()), 64'd5);
        b = int'(eff) * 5;
        for (int k = 0; k < 5; k++) begin
            if (rd_log.size() > k) check("rd_addr", 64'(rd_log[k]), 64'((b + k) % MEM_BYTES));
        end
    endtask

    initial begin
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h10; mem[1] = 8'h00; mem[2] = 8'h01; mem[3] = 8'h00; mem[4] = 8'h2A;
        pmem_bus.rd_data = 8'h00;
        reset = 1'b1; fetch_req = 1'b0; pc_load = 1'b0; next_pc = '0;
        m_pc = '0; m_instr = '0; m_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        check("reset_busy",  64'(busy), 64'd0);
        check("reset_rden",  64'(pmem_bus.rd_en), 64'd0);
        check("reset_addr",  64'(pmem_bus.addr),  64'd0);
        check("reset_fault", 64'(fetch_fault),    64'd0);
        reset = 1'b0;
        @(negedge clk);

        fetch(1'b0, 16'd0, 0, 16'd0, 1'b0);
        check("first_word", 64'(instruction), 64'h100001002A);

        load_pc(16'd3);
        fetch(1'b0, 16'd0, 0, 16'd0, 1'b0);

        fetch(1'b1, 16'd7, 0, 16'd0, 1'b0);

        fetch(1'b0, 16'd0, 3, 16'd9, 1'b0);
        check("mid_pc", 64'(pc), 64'd9);

        fetch(1'b0, 16'd0, 0, 16'd0, 1'b1);
        fetch(1'b0, 16'd0, 6, 16'd11, 1'b0);

`ifndef IFU_BOUNDS_EN
        load_pc(16'hFFFF);
        fetch(1'b0, 16'd0, 0, 16'd0, 1'b0);
`endif

        for (int it = 0; it < 25; it++) begin
            int mode;
            mode = int'($urandom_range(0, 4));
            case (mode)
                0: fetch(1'b0, 16'd0, 0, 16'd0, 1'b0);
                1: fetch(1'b1, 16'($urandom_range(0, 4095)), 0, 16'd0, 1'b0);
                2: begin
                    load_pc(16'($urandom_range(0, 4095)));
                    fetch(1'b0, 16'd0, 0, 16'd0, 1'b0);
                end
                3: fetch(1'b0, 16'd0, int'($urandom_range(1, 6)), 16'($urandom_range(0, 4095)), 1'b0);
                default: fetch(1'b0, 16'd0, 0, 16'd0, 1'b1);
            endcase
        end

        // reset asserted during T+3 of a fetch
        load_pc(16'd20);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        m_pc    = '0;
        m_instr = '0;
        m_valid = 1'b0;
        check_outputs("rst_mid");
        check("rst_mid_busy", 64'(busy),           64'd0);
        check("rst_mid_rden", 64'(pmem_bus.rd_en), 64'd0);
        check("rst_mid_addr", 64'(pmem_bus.addr),  64'd0);
        repeat (6) @(negedge clk);
        check_outputs("rst_late");
        check("rst_late_rden", 64'(pmem_bus.rd_en), 64'd0);

`ifdef IFU_BOUNDS_EN
        load_pc(16'd4096);
        rd_log.delete();
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        check("oob_busy",  64'(busy),        64'd1);
        check("oob_valid0", 64'(instr_valid), 64'd0);
        @(negedge clk);
        m_instr = 40'hFF00000000;
        m_valid = 1'b1;
        check_outputs("oob");
        check("oob_fault", 64'(fetch_fault),    64'd1);
        check("oob_reads", 64'(rd_log.size()),  64'd0);
        repeat (3) @(negedge clk);
        check("oob_hold",  64'(fetch_fault),    64'd1);
        load_pc(16'd1);
        fetch(1'b0, 16'd0, 0, 16'd0, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
